// File: rtl/z_path_pipe_addsub.sv
// Carry-pipelined adder/subtractor: one SLICE-bit carry segment per stage, with
// operand skew ahead of the stages and sum deskew behind them so results emerge aligned.
module z_path_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             CE,
  input  logic             VIN,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             VOUT,
  output logic [WIDTH-1:0] Sreg,
  output logic             Cout,
  output logic             OVF
);
  localparam int NSL = WIDTH / SLICE;

  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic [NSL:0]     carry_s;
  logic [NSL-1:0]   vld_r;
  logic             ovf_r;

  // Subtraction folds into the addend and the slice-0 carry, so SUB never needs skewing
  always_comb begin
    b_eff_s = B;
    c0_s    = Cin;
    if (SUB) begin
      b_eff_s = ~B;
      c0_s    = 1'b1;
    end else begin
      b_eff_s = B;
      c0_s    = Cin;
    end
  end

  assign carry_s[0] = c0_s;

  genvar k;
  generate
    for (k = 0; k < NSL; k++) begin : g_sl
      logic [SLICE-1:0] a_sk_s;
      logic [SLICE-1:0] b_sk_s;
      logic [SLICE:0]   sum_s;
      logic [SLICE-1:0] sum_r;
      logic             carry_r;
      logic [SLICE-1:0] out_s;

      if (k == 0) begin : g_head
        assign a_sk_s = A[SLICE-1:0];
        assign b_sk_s = b_eff_s[SLICE-1:0];
      end else begin : g_skew
        logic [SLICE-1:0] a_dly_r [k];
        logic [SLICE-1:0] b_dly_r [k];

        // Operand skew: slice k waits k enabled cycles for the carry of slice k-1
        always_ff @(posedge C or negedge CLR_N) begin
          if (!CLR_N) begin
            for (int j = 0; j < k; j++) begin
              a_dly_r[j] <= {SLICE{1'b0}};
              b_dly_r[j] <= {SLICE{1'b0}};
            end
          end else if (CE) begin
            a_dly_r[0] <= A[k*SLICE +: SLICE];
            b_dly_r[0] <= b_eff_s[k*SLICE +: SLICE];
            for (int j = 1; j < k; j++) begin
              a_dly_r[j] <= a_dly_r[j-1];
              b_dly_r[j] <= b_dly_r[j-1];
            end
          end
        end

        assign a_sk_s = a_dly_r[k-1];
        assign b_sk_s = b_dly_r[k-1];
      end

      assign sum_s = {1'b0, a_sk_s} + {1'b0, b_sk_s} + {{SLICE{1'b0}}, carry_s[k]};

      // Stage register: slice sum plus the carry handed to the next slice
      always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
          sum_r   <= {SLICE{1'b0}};
          carry_r <= 1'b0;
        end else if (CE) begin
          sum_r   <= sum_s[SLICE-1:0];
          carry_r <= sum_s[SLICE];
        end
      end

      assign carry_s[k+1] = carry_r;

      if (k == NSL-1) begin : g_top
        assign out_s = sum_r;

        // Signed overflow is judged on the top slice's addend and result signs
        always_ff @(posedge C or negedge CLR_N) begin
          if (!CLR_N) begin
            ovf_r <= 1'b0;
          end else if (CE) begin
            ovf_r <= (a_sk_s[SLICE-1] == b_sk_s[SLICE-1]) &&
                     (sum_s[SLICE-1] != a_sk_s[SLICE-1]);
          end
        end
      end else begin : g_dsk
        logic [SLICE-1:0] dsk_r [NSL-1-k];

        // Sum deskew: lower slices finish early and wait for the top slice
        always_ff @(posedge C or negedge CLR_N) begin
          if (!CLR_N) begin
            for (int j = 0; j < NSL-1-k; j++) begin
              dsk_r[j] <= {SLICE{1'b0}};
            end
          end else if (CE) begin
            dsk_r[0] <= sum_r;
            for (int j = 1; j < NSL-1-k; j++) begin
              dsk_r[j] <= dsk_r[j-1];
            end
          end
        end

        assign out_s = dsk_r[NSL-2-k];
      end

      assign Sreg[k*SLICE +: SLICE] = out_s;
    end
  endgenerate

  // Valid pipeline moves in lockstep with the data slices
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      vld_r <= {NSL{1'b0}};
    end else if (CE) begin
      vld_r[0] <= VIN;
      for (int j = 1; j < NSL; j++) begin
        vld_r[j] <= vld_r[j-1];
      end
    end
  end

  assign VOUT = vld_r[NSL-1];
  assign Cout = carry_s[NSL];
  assign OVF  = ovf_r;

endmodule

// File: tb/tb_z_path_pipe_addsub.sv
// Bench for z_path_pipe_addsub: four parameterisations side by side, checked against an
// arithmetic model indexed by enabled clock edges.
module tb_z_path_pipe_addsub;
  typedef struct packed {
    logic        vin;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n, ce, vin, sub, cin;
  logic [31:0] a, b;

  logic        vo0, vo1, vo2, vo3, co0, co1, co2, co3, ov0, ov1, ov2, ov3;
  logic [31:0] s0;
  logic [15:0] s1;
  logic [23:0] s2;
  logic [7:0]  s3;
  logic [34:0] obs [4];

  int  tests = 0;
  int  fails = 0;
  int  wid [4];
  int  nsl [4];
  op_t hq [$];

  always #5 clk = ~clk;

  z_path_pipe_addsub #(.WIDTH(32), .SLICE(8)) u_w32 (.C(clk), .CLR_N(rst_n), .CE(ce), .VIN(vin),
    .SUB(sub), .A(a), .B(b), .Cin(cin), .VOUT(vo0), .Sreg(s0), .Cout(co0), .OVF(ov0));
  z_path_pipe_addsub #(.WIDTH(16), .SLICE(4)) u_w16 (.C(clk), .CLR_N(rst_n), .CE(ce), .VIN(vin),
    .SUB(sub), .A(a[15:0]), .B(b[15:0]), .Cin(cin), .VOUT(vo1), .Sreg(s1), .Cout(co1), .OVF(ov1));
  z_path_pipe_addsub #(.WIDTH(24), .SLICE(8)) u_w24 (.C(clk), .CLR_N(rst_n), .CE(ce), .VIN(vin),
    .SUB(sub), .A(a[23:0]), .B(b[23:0]), .Cin(cin), .VOUT(vo2), .Sreg(s2), .Cout(co2), .OVF(ov2));
  z_path_pipe_addsub #(.WIDTH(8), .SLICE(8)) u_w8 (.C(clk), .CLR_N(rst_n), .CE(ce), .VIN(vin),
    .SUB(sub), .A(a[7:0]), .B(b[7:0]), .Cin(cin), .VOUT(vo3), .Sreg(s3), .Cout(co3), .OVF(ov3));

  assign obs[0] = {vo0, ov0, co0, s0};
  assign obs[1] = {vo1, ov1, co1, 16'h0000, s1};
  assign obs[2] = {vo2, ov2, co2, 8'h00, s2};
  assign obs[3] = {vo3, ov3, co3, 24'h000000, s3};

  // Plain integer arithmetic: unsigned sum/difference for result and carry, exact signed value for overflow
  function automatic logic [34:0] model(int w, op_t o);
    longint unsigned full, ua, ub, usum;
    longint          sa, sb, exact, smax;
    logic            co, ov;
    full = 64'd1 << w;
    ua   = {32'h0, o.a} & (full - 64'd1);
    ub   = {32'h0, o.b} & (full - 64'd1);
    smax = longint'(full >> 1) - 64'sd1;
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (ua >= (full >> 1)) sa = sa - longint'(full);
    if (ub >= (full >> 1)) sb = sb - longint'(full);
    if (o.sub) begin
      exact = sa - sb;
      co    = (ua >= ub);
      usum  = (ua - ub) & (full - 64'd1);
    end else begin
      exact = sa + sb + longint'({63'd0, o.cin});
      usum  = ua + ub + {63'd0, o.cin};
      co    = (usum >= full);
      usum  = usum & (full - 64'd1);
    end
    ov = (exact > smax) || (exact < (-smax - 64'sd1));
    return {1'b1, ov, co, usum[31:0]};
  endfunction

  function automatic logic [34:0] expect_out(int d);
    op_t o;
    if (hq.size() < nsl[d]) return 35'd0;
    o = hq[hq.size() - nsl[d]];
    if (!o.vin) return 35'd0;
    return model(wid[d], o);
  endfunction

  task automatic clk_step();
    @(posedge clk);
    if (ce && rst_n) hq.push_back(op_t'({vin, sub, cin, a, b}));
    #1;
  endtask

  task automatic drive(logic v, logic s, logic c, logic [31:0] ta, logic [31:0] tb);
    vin = v; sub = s; cin = c; a = ta; b = tb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) ce = 1'b1;
      clk_step();
      for (int d = 0; d < 4; d++) begin
        tests++;
        if (obs[d] !== 35'd0) begin
          fails++;
          $display("FAIL reset dut%0d got=%h exp=%h", d, obs[d], 35'd0);
        end
      end
    end
    #2 rst_n = 1'b1;
    hq.delete();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_directed();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [34:0] e;
    ta = '{32'h000000FF, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    tb = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h00000001};
    ce = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 4) drive(1'b1, (i == 2), (i == 1), ta[i], tb[i]);
      else       drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      clk_step();
      for (int d = 0; d < 4; d++) begin
        e = expect_out(d);
        tests++;
        if (obs[d][34] !== e[34] || (e[34] && obs[d] !== e)) begin
          fails++;
          $display("FAIL directed dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], e);
        end
      end
    end
    // Hand-derived 32-bit results for the ripple and overflow vectors as they stream out
    tests++;
    if (hq.size() < 9 || model(32, hq[hq.size() - 9]) !== {1'b1, 1'b0, 1'b0, 32'h00000100}) begin
      fails++;
      $display("FAIL ripple_const got=%h exp=%h", model(32, hq[hq.size() - 9]), {3'b100, 32'h00000100});
    end
  endtask

  task automatic test_stream();
    logic [34:0] e;
    ce = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i < 8) drive(1'b1, i[0], 1'($urandom), $urandom, $urandom);
      else       drive(1'b0, 1'b0, 1'b0, $urandom, $urandom);
      clk_step();
      for (int d = 0; d < 4; d++) begin
        e = expect_out(d);
        tests++;
        if (obs[d][34] !== e[34] || (e[34] && obs[d] !== e)) begin
          fails++;
          $display("FAIL stream dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], e);
        end
      end
    end
  endtask

  task automatic test_ce_stall();
    logic [34:0] e;
    for (int i = 0; i < 12; i++) begin
      ce = !(i >= 2 && i <= 4);
      if (i < 2 || i == 5 || i == 6) drive(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
      else if (i <= 4)               drive(1'b1, 1'b1, 1'b1, $urandom, $urandom);
      else                           drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      clk_step();
      for (int d = 0; d < 4; d++) begin
        e = expect_out(d);
        tests++;
        if (obs[d][34] !== e[34] || (e[34] && obs[d] !== e)) begin
          fails++;
          $display("FAIL ce_stall dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], e);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [34:0] e;
    ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
      clk_step();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (obs[d] !== 35'd0) begin
        fails++;
        $display("FAIL midreset_clear dut%0d got=%h exp=%h", d, obs[d], 35'd0);
      end
    end
    #2 rst_n = 1'b1;
    hq.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) drive(1'b1, 1'b0, 1'b1, 32'h0000FFFF, 32'h0000FFFF);
      else        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      clk_step();
      for (int d = 0; d < 4; d++) begin
        e = expect_out(d);
        tests++;
        if (obs[d][34] !== e[34] || (e[34] && obs[d] !== e)) begin
          fails++;
          $display("FAIL midreset dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], e);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [34:0] e;
    logic [31:0] corner [4];
    corner = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 80; i++) begin
      ce = ($urandom_range(3) != 0);
      drive(1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom,
            ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom);
      clk_step();
      for (int d = 0; d < 4; d++) begin
        e = expect_out(d);
        tests++;
        if (obs[d][34] !== e[34] || (e[34] && obs[d] !== e)) begin
          fails++;
          $display("FAIL random dut%0d cyc%0d got=%h exp=%h", d, i, obs[d], e);
        end
      end
    end
  endtask

  initial begin
    wid = '{32, 16, 24, 8};
    nsl = '{4, 4, 3, 1};
    test_reset();
    test_directed();
    test_stream();
    test_ce_stall();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
